ls_ctrl: RTL
============

Name: ls_ctrl

Overview:
- Sequencing controller for the load/store reservation station.
- Watches the station's single entry until its operands are unlocked, then computes the effective address.
- Performs the access as a little-endian byte-serial sequence over the shared 8-bit memory port, sign/zero-extends load data and broadcasts the result on the common data bus.
- Drives busy_ls back to the station to hold the entry until completion; the station's outputs are registered on negedge.

Parameters:
- TAG_W, 4, register tag width.
- UNLOCKED, 4'b1111, tag value meaning "operand data valid".

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; 0 freezes all state.
- ls_busy_in  in  1  station entry valid.
- ls_op_in  in  4  {is_store, funct3}.
- ls_offset_in  in  32  immediate.
- ls_tagx_in  in  TAG_W  base tag.
- ls_tagy_in  in  TAG_W  store-data tag.
- ls_tagw_in  in  TAG_W  destination tag.
- ls_datax_in  in  32  base value.
- ls_datay_in  in  32  store data.
- ls_target_in  in  5  destination register.
- mem_gnt  in  1  port granted this cycle.
- mem_din  in  8  read byte.
- mem_req  out  1  port request.
- mem_a  out  32  byte address.
- mem_dout  out  8  write byte.
- mem_wr  out  1  write strobe.
- busy_ls  out  1  entry still owned.
- en_ls  out  1  result broadcast valid.
- ls_data  out  32  result.
- ls_tag_out  out  TAG_W  result tag.
- ls_target_out  out  5  result register.

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters 0. Reset mid-access aborts immediately: no further bytes, no broadcast.
- rdy=0: state, counters and outputs hold, except mem_wr is forced 0. A grant in such a cycle is not consumed.
- States and transitions:
  - IDLE: if ls_busy_in=1, go to WAIT and set busy_ls=1.
  - WAIT: operands are ready when tagx==UNLOCKED, and for stores also tagy==UNLOCKED. Operand values are sampled live from the station each cycle. When ready, latch addr=datax+offset (mod 2^32), op, datay, tagw and target, set n=1/2/4 from funct3[1:0]=00/01/other, then go to ACC.
  - ACC: mem_req=1, mem_a=addr+k.
    - Store: mem_dout=datay[8k+7:8k], mem_wr=1.
    - A cycle with mem_gnt=1 consumes byte k and increments k.
    - Load: the byte issued in cycle t is sampled from mem_din at t+1 into result[8k+7:8k]. Issuing continues back-to-back while granted.
    - After byte n-1 is granted: a store goes to DONE; a load goes to CAP.
  - CAP (loads only): capture the last byte; mem_req=0.
  - DONE: one cycle.
    - Load: en_ls=1, ls_tag_out=tagw, ls_target_out=target. ls_data is the extended value: funct3[2]=0 sign-extends, 1 zero-extends. Word loads pass through unchanged.
    - Store: en_ls=0.
    - busy_ls=0 in this cycle. Next state IDLE.
- busy_ls is registered. It is 1 from the cycle after acceptance through the cycle before DONE.
- The station drops busy at the DONE negedge, so IDLE never re-accepts a completed entry.
- Grant gaps: mem_req stays high and addr/k hold. A load still captures the previously issued byte the cycle after its grant.
- Latency: LW with continuous grant and ready operands is accept (IDLE) → WAIT → 4×ACC → CAP → DONE, giving en_ls 7 cycles after the first sampled ls_busy_in. LB gives en_ls 4 cycles after. SW reaches DONE 6 cycles after.
- Address wrap: 0xFFFFFFFF+1 wraps to 0. Misalignment is allowed; no trap.
- funct3 values 011, 110 and 111 are treated as a word access.

Test Plan:
1. LW, tagx=UNLOCKED, datax=0x100, offset=4, memory 0x104..107 = 78 56 34 12, gnt=1 → mem_a = 0x104..0x107 in consecutive cycles; en_ls=1 with ls_data=0x12345678 and tag/target echoed; busy_ls=0 in the same cycle.
2. LB and LBU at a byte of 0x80 → ls_data=0xFFFFFF80 and 0x00000080 respectively. LH of 0x8001 → 0xFFFF8001.
3. SW, tagy locked for 3 cycles, then datay=0xDEADBEEF → no mem_req while WAIT; then mem_wr=1 with bytes EF BE AD DE at addr..addr+3; en_ls never asserted.
4. LW with gnt toggling 1,0,1,0,... → mem_a holds during gap cycles; ls_data is still 0x12345678; no duplicate or dropped byte.
5. rdy=0 for 2 cycles mid-SW → mem_wr=0 and k frozen; sequence resumes with correct bytes. Also: rst asserted mid-LW → next cycle all outputs 0, IDLE, no en_ls.
6. datax=0xFFFFFFFE, offset=0, LW → mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.

Source files
------------

// File: rtl/ls_ctrl.sv
// Load/store sequencing controller: waits for unlocked operands, then runs a
// little-endian byte-serial access on the 8-bit memory port and broadcasts loads.
module ls_ctrl #(
  parameter int                TAG_W    = 4,
  parameter logic [TAG_W-1:0]  UNLOCKED = {TAG_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ls_busy_in,
  input  logic [3:0]        ls_op_in,
  input  logic [31:0]       ls_offset_in,
  input  logic [TAG_W-1:0]  ls_tagx_in,
  input  logic [TAG_W-1:0]  ls_tagy_in,
  input  logic [TAG_W-1:0]  ls_tagw_in,
  input  logic [31:0]       ls_datax_in,
  input  logic [31:0]       ls_datay_in,
  input  logic [4:0]        ls_target_in,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_din,
  output logic              mem_req,
  output logic [31:0]       mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  output logic              busy_ls,
  output logic              en_ls,
  output logic [31:0]       ls_data,
  output logic [TAG_W-1:0]  ls_tag_out,
  output logic [4:0]        ls_target_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    ACC  = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [31:0]        addr_r, datay_r, result_r;
  logic [3:0]         op_r;
  logic [TAG_W-1:0]   tagw_r;
  logic [4:0]         target_r;
  logic [2:0]         n_r, k_r, n_s;
  logic               pend_r;
  logic [1:0]         pend_k_r;
  logic               ready_s, last_s;
  logic [31:0]        merged_s, ext_s;

  // Operand readiness and access length of the entry currently offered
  always_comb begin
    ready_s = (ls_tagx_in == UNLOCKED) && (!ls_op_in[3] || (ls_tagy_in == UNLOCKED));
    last_s  = (k_r == (n_r - 3'd1));
    case (ls_op_in[1:0])
      2'b00:   n_s = 3'd1;
      2'b01:   n_s = 3'd2;
      default: n_s = 3'd4;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: if (ls_busy_in) state_s = WAIT; else state_s = IDLE;
      WAIT: if (ready_s) state_s = ACC; else state_s = WAIT;
      ACC: begin
        if (mem_gnt && last_s) state_s = op_r[3] ? DONE : CAP;
        else                   state_s = ACC;
      end
      CAP:     state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Load value with the in-flight byte merged in, then sign/zero extended
  always_comb begin
    merged_s = result_r;
    if (pend_r) merged_s[{pend_k_r, 3'b000} +: 8] = mem_din;
    else        merged_s = result_r;
    case (op_r[1:0])
      2'b00:   ext_s = op_r[2] ? {24'd0, merged_s[7:0]}  : {{24{merged_s[7]}}, merged_s[7:0]};
      2'b01:   ext_s = op_r[2] ? {16'd0, merged_s[15:0]} : {{16{merged_s[15]}}, merged_s[15:0]};
      default: ext_s = merged_s;
    endcase
  end

  // Memory port drive; the write strobe is suppressed while rdy is low
  always_comb begin
    if (state_r == ACC) begin
      mem_req = 1'b1;
      mem_a   = addr_r + {29'd0, k_r};
      if (op_r[3]) begin
        mem_dout = datay_r[{k_r[1:0], 3'b000} +: 8];
        mem_wr   = rdy;
      end else begin
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
      end
    end else begin
      mem_req  = 1'b0;
      mem_a    = 32'd0;
      mem_dout = 8'd0;
      mem_wr   = 1'b0;
    end
  end

  // State, access context and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      addr_r        <= 32'd0;
      datay_r       <= 32'd0;
      result_r      <= 32'd0;
      op_r          <= 4'd0;
      tagw_r        <= '0;
      target_r      <= 5'd0;
      n_r           <= 3'd0;
      k_r           <= 3'd0;
      pend_r        <= 1'b0;
      pend_k_r      <= 2'd0;
      busy_ls       <= 1'b0;
      en_ls         <= 1'b0;
      ls_data       <= 32'd0;
      ls_tag_out    <= '0;
      ls_target_out <= 5'd0;
    end else if (rdy) begin
      state_r <= state_s;
      if ((state_r == WAIT) && ready_s) begin
        addr_r   <= ls_datax_in + ls_offset_in;
        op_r     <= ls_op_in;
        datay_r  <= ls_datay_in;
        tagw_r   <= ls_tagw_in;
        target_r <= ls_target_in;
        n_r      <= n_s;
        k_r      <= 3'd0;
        result_r <= 32'd0;
      end else if ((state_r == ACC) && mem_gnt) begin
        k_r <= k_r + 3'd1;
      end else begin
        k_r <= k_r;
      end
      // A granted load byte arrives on mem_din one cycle later
      pend_r   <= (state_r == ACC) && mem_gnt && !op_r[3];
      pend_k_r <= k_r[1:0];
      if (pend_r) result_r <= merged_s;
      busy_ls <= (state_s == WAIT) || (state_s == ACC) || (state_s == CAP);
      if ((state_s == DONE) && !op_r[3]) begin
        en_ls         <= 1'b1;
        ls_data       <= ext_s;
        ls_tag_out    <= tagw_r;
        ls_target_out <= target_r;
      end else begin
        en_ls         <= 1'b0;
        ls_data       <= 32'd0;
        ls_tag_out    <= '0;
        ls_target_out <= 5'd0;
      end
    end
  end

endmodule
